// File: rtl/fifo_rr_read_scheduler.sv
// Round-robin read scheduler: grants one of NUM_Q attached FIFOs at a time,
// reads up to BURST_LEN words from it and funnels them, tagged with their
// source queue id, into a 2-entry output buffer.
//
// Handshakes:
//   - Downstream port is strict valid/ready. A word transfers in a cycle where
//     out_valid && out_ready. While out_valid is high and out_ready is low,
//     out_data/out_qid hold their value and out_valid stays high.
//   - Upstream FIFOs: q_rd_en[i] high in cycle c with q_empty[i] low pops one
//     word, and that word is presented on lane i of q_rd_data in cycle c+1 only.
//     A read is issued only when the output buffer is guaranteed to have room
//     for it one cycle later, so captured words are never dropped.
module fifo_rr_read_scheduler #(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int QID_WIDTH  = $clog2(NUM_Q)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_Q-1:0]            q_empty,
    input  logic [NUM_Q*DATA_WIDTH-1:0] q_rd_data,
    output logic [NUM_Q-1:0]            q_rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [QID_WIDTH-1:0]        out_qid,
    output logic                        busy
);

    localparam int BC_W = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Scheduler state
    state_t                state_q, state_d;
    logic [QID_WIDTH-1:0]  grant_q, grant_d;
    logic [QID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [QID_WIDTH-1:0]  inflight_qid_q, inflight_qid_d;

    // Output buffer state (2 entries, circular)
    logic [1:0]                 buf_cnt_q, buf_cnt_d;
    logic                       buf_rd_ptr_q, buf_rd_ptr_d;
    logic                       buf_wr_ptr_q, buf_wr_ptr_d;
    logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [1:0][QID_WIDTH-1:0]  buf_qid_q, buf_qid_d;

    // Internal combinational signals
    logic                  hit_hi, hit_lo;
    logic [QID_WIDTH-1:0]  idx_hi, idx_lo;
    logic                  found;
    logic [QID_WIDTH-1:0]  found_idx;
    logic                  grant_empty;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  issue;
    logic [QID_WIDTH-1:0]  next_ptr;
    logic [BC_W-1:0]       burst_cnt_inc;
    logic [DATA_WIDTH-1:0] cap_data;

    // Round-robin search: lowest non-empty index at or above rr_ptr, else the
    // lowest non-empty index overall (the wrap-around case).
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (!q_empty[i]) begin
                hit_lo = 1'b1;
                idx_lo = QID_WIDTH'(i);
                if (QID_WIDTH'(i) >= rr_ptr_q) begin
                    hit_hi = 1'b1;
                    idx_hi = QID_WIDTH'(i);
                end
            end
        end
        found     = hit_lo;
        found_idx = hit_hi ? idx_hi : idx_lo;
    end

    // Empty flag of the currently granted FIFO.
    always_comb begin
        grant_empty = 1'b1;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant_q == QID_WIDTH'(i)) begin
                grant_empty = q_empty[i];
            end
        end
    end

    // Read issue decision: the buffer must have a free slot once the word
    // that is already in flight (if any) and this cycle's pop are accounted for.
    always_comb begin
        pop       = (buf_cnt_q != 2'd0) && out_ready;
        occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = !rst && (state_q == ST_BURST) && !grant_empty && (occupancy < 3'd2);
        next_ptr  = (grant_q == QID_WIDTH'(NUM_Q - 1)) ? '0 : grant_q + QID_WIDTH'(1);
        burst_cnt_inc = burst_cnt_q + BC_W'(1);
    end

    // Next-state logic of the IDLE/BURST scheduler and the in-flight tracker.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        inflight_d     = issue;
        inflight_qid_d = issue ? grant_q : inflight_qid_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d     = found_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (grant_empty) begin
                    // Granted FIFO ran dry: hand over to the next queue.
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (issue) begin
                    burst_cnt_d = burst_cnt_inc;
                    if (burst_cnt_inc == BC_W'(BURST_LEN)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
                // Otherwise stalled on buffer credit: hold everything.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-hot read enable towards the granted FIFO.
    always_comb begin
        q_rd_en = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (issue && (grant_q == QID_WIDTH'(i))) begin
                q_rd_en[i] = 1'b1;
            end
        end
    end

    // Lane select for the word returned by the read issued last cycle.
    always_comb begin
        cap_data = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (inflight_qid_q == QID_WIDTH'(i)) begin
                cap_data = q_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output buffer: capture at the write pointer, pop at the read pointer.
    always_comb begin
        buf_data_d   = buf_data_q;
        buf_qid_d    = buf_qid_q;
        buf_wr_ptr_d = buf_wr_ptr_q;
        buf_rd_ptr_d = buf_rd_ptr_q;
        if (inflight_q) begin
            buf_data_d[buf_wr_ptr_q] = cap_data;
            buf_qid_d[buf_wr_ptr_q]  = inflight_qid_q;
            buf_wr_ptr_d             = ~buf_wr_ptr_q;
        end
        if (pop) begin
            buf_rd_ptr_d = ~buf_rd_ptr_q;
        end
        buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // Outputs derived purely from registered state.
    always_comb begin
        out_valid = (buf_cnt_q != 2'd0);
        out_data  = buf_data_q[buf_rd_ptr_q];
        out_qid   = buf_qid_q[buf_rd_ptr_q];
        busy      = (state_q == ST_BURST) || inflight_q || (buf_cnt_q != 2'd0);
    end

    // State registers; reset also discards in-flight and buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            burst_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_qid_q <= '0;
            buf_cnt_q      <= 2'd0;
            buf_rd_ptr_q   <= 1'b0;
            buf_wr_ptr_q   <= 1'b0;
            buf_data_q     <= '0;
            buf_qid_q      <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            burst_cnt_q    <= burst_cnt_d;
            inflight_q     <= inflight_d;
            inflight_qid_q <= inflight_qid_d;
            buf_cnt_q      <= buf_cnt_d;
            buf_rd_ptr_q   <= buf_rd_ptr_d;
            buf_wr_ptr_q   <= buf_wr_ptr_d;
            buf_data_q     <= buf_data_d;
            buf_qid_q      <= buf_qid_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// Bench for fifo_rr_read_scheduler: behavioural FIFO models feed the DUT,
// a round-robin reference model predicts read order and output words.
module tb_fifo_rr_read_scheduler;

    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int QW = 2;
    localparam int W  = QW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NQ-1:0]    q_empty;
    logic [NQ*DW-1:0] q_rd_data;
    logic [NQ-1:0]    q_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [QW-1:0]    out_qid;
    logic             busy;

    fifo_rr_read_scheduler #(
        .NUM_Q(NQ), .DATA_WIDTH(DW), .BURST_LEN(BL), .QID_WIDTH(QW)
    ) dut (
        .clk(clk), .rst(rst), .q_empty(q_empty), .q_rd_data(q_rd_data),
        .q_rd_en(q_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_qid(out_qid), .busy(busy)
    );

    // ---------------- bench state ----------------
    logic [DW-1:0] fifo [NQ][$];
    logic [W-1:0]  exp_q[$];
    int            exp_rd_qid[$];
    int            obs_run_qid[$];
    int            obs_run_len[$];
    int            checks, errors;
    int            cyc, load_cyc, first_rd_cyc, first_out_cyc;
    int            rd_count, prev_rd_q, last_rd_q;
    int            ready_mode;
    logic          hold_valid;
    logic [W-1:0]  hold_word;

    typedef struct packed {
        logic [15:0] cnt;    // nibble q = words preloaded into FIFO q
        logic [3:0]  nruns;
        logic [63:0] runs;   // byte k = {qid, length} of k-th burst
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NQ; i++) q_empty[i] = (fifo[i].size() == 0);
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock cycle: observe at negedge, update FIFO models after posedge.
    task automatic tick();
        int rd_q;
        logic [DW-1:0] w;
        rd_q = -1;
        w = '0;
        @(negedge clk);
        if (!rst) begin
            check("rd_en_onehot", ($countones(q_rd_en) <= 1), 1);
            check("rd_en_while_empty", |(q_rd_en & q_empty), 0);
            for (int i = 0; i < NQ; i++) if (q_rd_en[i]) rd_q = i;
            if (rd_q >= 0) begin
                if (fifo[rd_q].size() != 0) w = fifo[rd_q].pop_front();
                rd_count++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (rd_q == prev_rd_q) begin
                    obs_run_len[obs_run_len.size()-1] += 1;
                end else begin
                    obs_run_qid.push_back(rd_q);
                    obs_run_len.push_back(1);
                end
                if (exp_rd_qid.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_qid", rd_q, exp_rd_qid.pop_front());
                last_rd_q = rd_q;
            end
            prev_rd_q = rd_q;
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (hold_valid) check("out_hold", {out_valid, out_qid, out_data}, {1'b1, hold_word});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", {out_qid, out_data}, 0);
                else check("out_word", {out_qid, out_data}, exp_q.pop_front());
            end
            hold_valid = out_valid && !out_ready;
            hold_word  = {out_qid, out_data};
        end else begin
            prev_rd_q  = -1;
            hold_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NQ; i++)
            q_rd_data[i*DW +: DW] = (i == rd_q) ? w : DW'($urandom);
        drive_inputs();
    endtask

    // Reference: walk queues round-robin from start, taking min(BL, remaining).
    task automatic build_model(input int start);
        int rem[NQ];
        int taken[NQ];
        int p, q, n;
        bit any;
        for (int i = 0; i < NQ; i++) begin
            rem[i] = fifo[i].size();
            taken[i] = 0;
        end
        p = start;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            q = 0;
            for (int k = 0; k < NQ; k++)
                if (!any && rem[(p + k) % NQ] > 0) begin
                    any = 1'b1;
                    q = (p + k) % NQ;
                end
            if (any) begin
                n = (rem[q] < BL) ? rem[q] : BL;
                for (int j = 0; j < n; j++) begin
                    exp_rd_qid.push_back(q);
                    exp_q.push_back({QW'(q), fifo[q][taken[q] + j]});
                end
                taken[q] += n;
                rem[q]   -= n;
                p = (q + 1) % NQ;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        exp_q.delete();
        exp_rd_qid.delete();
        obs_run_qid.delete();
        obs_run_len.delete();
        rd_count = 0;
        first_rd_cyc = -1;
        first_out_cyc = -1;
        prev_rd_q = -1;
        last_rd_q = -1;
        hold_valid = 1'b0;
        drive_inputs();
        #2;
        check("rst_rd_en", q_rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_qid", out_qid, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic load(input logic [15:0] cnt, input bit rnd);
        for (int q = 0; q < NQ; q++) begin
            for (int j = 0; j < int'(cnt[q*4 +: 4]); j++)
                fifo[q].push_back(rnd ? DW'($urandom) : DW'(8'h81 + q*16 + j));
        end
        load_cyc = cyc;
        drive_inputs();
        build_model(0);
    endtask

    function automatic bit fifos_empty();
        for (int i = 0; i < NQ; i++) if (fifo[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_done(input int max);
        int n;
        bit done;
        n = 0;
        done = fifos_empty() && (exp_q.size() == 0) && !busy;
        while (!done && n < max) begin
            tick();
            n++;
            done = fifos_empty() && (exp_q.size() == 0) && !busy;
        end
        check("drain_timeout", done, 1);
    endtask

    task automatic check_runs(input int nruns, input logic [63:0] runs);
        check("run_count", obs_run_qid.size(), nruns);
        for (int k = 0; k < nruns; k++) begin
            if (k < obs_run_qid.size()) begin
                check("run_qid", obs_run_qid[k], runs[k*8+4 +: 4]);
                check("run_len", obs_run_len[k], runs[k*8 +: 4]);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, total;
        rst = 1'b1;
        q_empty = '1;
        q_rd_data = '0;
        out_ready = 1'b0;
        checks = 0;
        errors = 0;
        cyc = 0;
        ready_mode = 0;
        hold_valid = 1'b0;
        prev_rd_q = -1;

        vecs[0] = '{cnt: 16'h0300, nruns: 4'd1, runs: 64'h23};
        vecs[1] = '{cnt: 16'h8888, nruns: 4'd8, runs: 64'h34_24_14_04_34_24_14_04};
        vecs[2] = '{cnt: 16'h5020, nruns: 4'd3, runs: 64'h31_34_12};
        vecs[3] = '{cnt: 16'h0001, nruns: 4'd1, runs: 64'h01};
        vecs[4] = '{cnt: 16'h9000, nruns: 4'd3, runs: 64'h31_34_34};
        vecs[5] = '{cnt: 16'h1602, nruns: 4'd4, runs: 64'h22_31_24_02};
        vecs[6] = '{cnt: 16'h0000, nruns: 4'd0, runs: 64'h0};

        do_reset(2);

        // Table-driven scenarios with out_ready held high.
        for (int v = 0; v < 7; v++) begin
            ready_mode = 0;
            do_reset(1);
            load(vecs[v].cnt, 1'b0);
            total = 0;
            for (int q = 0; q < NQ; q++) total += int'(vecs[v].cnt[q*4 +: 4]);
            run_until_done(400);
            for (int i = 0; i < 3; i++) tick();
            check("idle_busy", busy, 0);
            check("rd_total", rd_count, total);
            check_runs(int'(vecs[v].nruns), vecs[v].runs);
            if (total != 0) begin
                check("first_rd_latency", first_rd_cyc - load_cyc, 1);
                check("first_out_latency", first_out_cyc - first_rd_cyc, 2);
            end
        end

        // Backpressure: stalled downstream allows exactly two reads.
        ready_mode = 1;
        do_reset(1);
        load(16'h0006, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        #2;
        check("bp_reads", rd_count, 2);
        check("bp_rd_en", q_rd_en, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_busy", busy, 1);
        ready_mode = 0;
        drive_inputs();
        run_until_done(200);
        check("bp_rd_total", rd_count, 6);

        // Reset right after a read: popped and buffered words are discarded,
        // round-robin pointer restarts at queue 0.
        ready_mode = 0;
        do_reset(1);
        load(16'h0360, 1'b0);
        n = 0;
        while (last_rd_q != 2 && n < 100) begin
            tick();
            n++;
        end
        check("saw_read_q2", last_rd_q, 2);
        do_reset(2);
        build_model(0);
        run_until_done(200);
        check_runs(2, 64'h22_12);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 20; r++) begin
            ready_mode = 2;
            do_reset(1);
            load({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))}, 1'b1);
            run_until_done(800);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_read_scheduler.md
FIFO_RR_READ_SCHEDULER -- requirements
Module: fifo_rr_read_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  NUM_Q, 4, number of attached FIFOs (>=2)
  DATA_WIDTH, 8, FIFO word width
  BURST_LEN, 4, max consecutive reads per grant (>=1)
  QID_WIDTH, $clog2(NUM_Q), queue-id width (derived)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  q_empty  in  NUM_Q  per-FIFO empty flag, bit i = FIFO i
  q_rd_data  in  NUM_Q*DATA_WIDTH  per-FIFO read data, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
  q_rd_en  out  NUM_Q  per-FIFO read enable, at most one bit high
  out_valid  out  1  output word valid
  out_ready  in  1  downstream accept
  out_data  out  DATA_WIDTH  output word
  out_qid  out  QID_WIDTH  source FIFO of out_data
  busy  out  1  grant active, read in flight or words buffered
REQ-003 The design SHALL use exactly one clock, clk; reset SHALL be synchronous and active-high on rst.

Function
REQ-004 Attached FIFO contract: q_rd_en[i] high in cycle c while q_empty[i]=0 pops one word; lane i of q_rd_data holds that word in cycle c+1 only.
REQ-005 q_rd_en[i] SHALL never be high while q_empty[i]=1.
REQ-006 FSM states: IDLE, BURST.
REQ-007 IDLE: search q_empty from rr_ptr upward, modulo NUM_Q; first non-empty index i SHALL be registered as grant, state -> BURST, burst_cnt <- 0; no read issued in IDLE.
REQ-008 IDLE with all FIFOs empty: stay IDLE; rr_ptr unchanged.
REQ-009 BURST: issue = !q_empty[grant] && (buf_cnt + inflight - pop) < 2, where pop = out_valid && out_ready; q_rd_en[grant] = issue.
REQ-010 Each issue: burst_cnt increments; inflight <- 1 with inflight_qid <- grant; no issue: inflight <- 0.
REQ-011 BURST -> IDLE when q_empty[grant]=1 (no issue that cycle) or on the issue that makes burst_cnt = BURST_LEN; both cases rr_ptr <- grant+1 modulo NUM_Q.
REQ-012 Backpressure stall (q_empty[grant]=0, credit exhausted) SHALL hold BURST and burst_cnt.
REQ-013 Output buffer: 2-entry FIFO of {data, qid}; cycle after an issue, lane inflight_qid of q_rd_data SHALL be written to it.
REQ-014 out_valid = buf_cnt != 0; out_data/out_qid = head entry; head SHALL hold stable while out_valid && !out_ready.
REQ-015 Simultaneous capture and pop SHALL be legal; buf_cnt never exceeds 2; no word lost, duplicated or reordered.
REQ-016 Latency: q_rd_en high in cycle c -> word on out at c+2 earliest; non-empty FIFO seen in IDLE at cycle t -> first q_rd_en at t+1.
REQ-017 Steady-state throughput with out_ready=1 SHALL be one word/cycle within a burst; one bubble cycle per IDLE pass.
REQ-018 busy = (state==BURST) || inflight || (buf_cnt != 0).
REQ-019 Counters: burst_cnt width $clog2(BURST_LEN+1); buf_cnt 2 bits; rr_ptr QID_WIDTH bits, wraps NUM_Q-1 -> 0.

Reset
REQ-020 rst=1 at a clock edge: state IDLE, rr_ptr 0, burst_cnt 0, inflight 0, buf_cnt 0; q_rd_en 0 combinationally while rst=1.
REQ-021 Post-reset outputs: q_rd_en 0, out_valid 0, out_data 0, out_qid 0, busy 0.
REQ-022 Reset mid-operation SHALL discard buffered and in-flight words; none appears on out after rst deasserts.

Verification
REQ-023 Reset: rst high 2 cycles during busy traffic -> next cycle out_valid=0, q_rd_en=0, busy=0, out_data=0.
REQ-024 FIFO 2 holds 0xA1,0xA2,0xA3, others empty, out_ready=1 -> q_rd_en[2] high 3 consecutive cycles; out words A1,A2,A3, out_qid=2, in order.
REQ-025 All 4 FIFOs hold 8 words, BURST_LEN=4 -> grant order 0,1,2,3,0,...; exactly 4 consecutive words per visit; 32 words out, per-queue order kept.
REQ-026 Backpressure: out_ready=0 with FIFO 0 non-empty -> exactly 2 reads, then q_rd_en=0; out_data stable; out_ready=1 -> remaining words, no loss/duplicate.
REQ-027 Early empty: FIFO 1 holds 2 words, FIFO 3 holds 5, BURST_LEN=4 -> 2 reads from 1, IDLE, then 4 from 3, IDLE, then 1 from 3.
REQ-028 rst pulsed the cycle after a q_rd_en -> popped word never appears on out; rr_ptr restarts at 0.
